// File: rtl/fetch_decode_stage_pkg.sv
// Shared xgriscv defines for the fetch/decode slice.
// Holds the default XLEN, reset PC and bubble encoding, the RV32 instruction
// field bit positions, and the fetch FSM state encoding.
package fetch_decode_stage_pkg;

    localparam int          DEF_XLEN      = 32;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int IMM12_LSB  = 20;
    localparam int IMM12_MSB  = 31;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

    typedef enum logic {
        FETCH_REQ  = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer between instruction return and the
// decode register, used while decode is stalled.
// Ports:
//   clk, reset           clock, async active-high reset
//   write                capture write_instr/write_pc, mark full
//   read                 entry consumed, mark empty (write wins if both)
//   clear                drop the entry (highest priority)
//   write_instr/pc       incoming entry
//   full                 entry valid
//   instr/pc             stored entry
module fetch_skid_buf
    import fetch_decode_stage_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            write,
    input  logic            read,
    input  logic            clear,
    input  logic [31:0]     write_instr,
    input  logic [XLEN-1:0] write_pc,
    output logic            full,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full  <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else begin
            if (clear)
                full <= 1'b0;
            else if (write)
                full <= 1'b1;
            else if (read)
                full <= 1'b0;

            if (write && !clear) begin
                instr <= write_instr;
                pc    <= write_pc;
            end
        end
    end

endmodule

// File: rtl/fetch_decode_stage.sv
// xgriscv IF stage plus IF/ID pipeline register.
// Issues single-outstanding instruction fetches, buffers one returned word
// while decode stalls, and presents decoded fields to the controller.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// FETCH_REQ  | offering a request at pc_f (when buffer empty)
// FETCH_WAIT | request accepted, waiting for the response (kill = discard it)
//
// Ports:
//   clk, reset                   clock, async active-high reset
//   imem_req_valid/ready/addr    fetch request handshake
//   imem_rsp_valid/data          instruction return
//   stall_d                      hold the decode register
//   redirect_valid/pc            taken branch / jump target
//   valid_d, instr_d, pc_d       decode slot contents
//   pcplus4_d                    pc_d + 4
//   opcode_d .. imm12_d          field slices of instr_d
module fetch_decode_stage
    import fetch_decode_stage_pkg::*;
#(
    parameter int               XLEN      = DEF_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(DEF_RESET_PC),
    parameter logic [31:0]      NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            stall_d,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            valid_d,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pcplus4_d,
    output logic [6:0]      opcode_d,
    output logic [2:0]      funct3_d,
    output logic [6:0]      funct7_d,
    output logic [4:0]      rd_d,
    output logic [4:0]      rs1_d,
    output logic [11:0]     imm12_d
);

    fetch_state_e    state, state_nx;
    logic            kill, kill_nx;
    logic [XLEN-1:0] pc_f, pc_nx;

    logic            handshake;
    logic            rsp_take;
    logic            deliver;
    logic [XLEN-1:0] deliver_pc;
    logic [XLEN-1:0] redirect_target;

    logic            buf_full;
    logic [31:0]     buf_instr;
    logic [XLEN-1:0] buf_pc;
    logic            buf_write;
    logic            buf_read;

    assign redirect_target = redirect_pc & ~XLEN'(3);
    // pc_f only moves in WAIT on a redirect, and that also kills the response,
    // so a delivered word always belongs to pc_f - 4.
    assign deliver_pc      = pc_f - XLEN'(4);

    always_comb begin
        imem_req_valid = !reset && (state == FETCH_REQ) && !buf_full && !kill;
        imem_addr      = pc_f;
        handshake      = imem_req_valid && imem_req_ready;
        rsp_take       = (state == FETCH_WAIT) && imem_rsp_valid;
        deliver        = rsp_take && !kill && !redirect_valid;
        buf_write      = deliver && (stall_d || buf_full);
        buf_read       = !stall_d && buf_full && !redirect_valid;
    end

    always_comb begin
        state_nx = state;
        kill_nx  = kill;
        pc_nx    = pc_f;

        case (state)
            FETCH_REQ: begin
                if (handshake) begin
                    pc_nx    = pc_f + XLEN'(4);
                    state_nx = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rsp_valid) begin
                    kill_nx  = 1'b0;
                    state_nx = FETCH_REQ;
                end
            end
        endcase

        if (redirect_valid) begin
            pc_nx = redirect_target;
            if (rsp_take) begin
                // the arriving response is simply dropped; nothing left in flight
                kill_nx  = 1'b0;
                state_nx = FETCH_REQ;
            end else if ((state == FETCH_WAIT) || handshake) begin
                kill_nx  = 1'b1;
                state_nx = FETCH_WAIT;
            end else begin
                kill_nx  = 1'b0;
                state_nx = FETCH_REQ;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH_REQ;
            kill  <= 1'b0;
            pc_f  <= RESET_PC;
        end else begin
            state <= state_nx;
            kill  <= kill_nx;
            pc_f  <= pc_nx;
        end
    end

    fetch_skid_buf #(.XLEN(XLEN)) u_skid (
        .clk         (clk),
        .reset       (reset),
        .write       (buf_write),
        .read        (buf_read),
        .clear       (redirect_valid),
        .write_instr (imem_rsp_data),
        .write_pc    (deliver_pc),
        .full        (buf_full),
        .instr       (buf_instr),
        .pc          (buf_pc)
    );

    // Bubbles keep pc_d so it still names the last real slot position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_d <= 1'b0;
            instr_d <= NOP_INSTR;
            pc_d    <= '0;
        end else if (redirect_valid) begin
            valid_d <= 1'b0;
            instr_d <= NOP_INSTR;
        end else if (!stall_d) begin
            if (buf_full) begin
                valid_d <= 1'b1;
                instr_d <= buf_instr;
                pc_d    <= buf_pc;
            end else if (deliver) begin
                valid_d <= 1'b1;
                instr_d <= imem_rsp_data;
                pc_d    <= deliver_pc;
            end else begin
                valid_d <= 1'b0;
                instr_d <= NOP_INSTR;
            end
        end
    end

    assign pcplus4_d = pc_d + XLEN'(4);
    assign opcode_d  = instr_d[OPCODE_MSB:OPCODE_LSB];
    assign funct3_d  = instr_d[FUNCT3_MSB:FUNCT3_LSB];
    assign funct7_d  = instr_d[FUNCT7_MSB:FUNCT7_LSB];
    assign rd_d      = instr_d[RD_MSB:RD_LSB];
    assign rs1_d     = instr_d[RS1_MSB:RS1_LSB];
    assign imm12_d   = instr_d[IMM12_MSB:IMM12_LSB];

endmodule

// File: tb/tb_fetch_decode_stage.sv
module tb_fetch_decode_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall_d;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic [6:0]  opcode_d;
    logic [2:0]  funct3_d;
    logic [6:0]  funct7_d;
    logic [4:0]  rd_d;
    logic [4:0]  rs1_d;
    logic [11:0] imm12_d;

    always #5 clk = ~clk;

    fetch_decode_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall_d        (stall_d),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .valid_d        (valid_d),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .pcplus4_d      (pcplus4_d),
        .opcode_d       (opcode_d),
        .funct3_d       (funct3_d),
        .funct7_d       (funct7_d),
        .rd_d           (rd_d),
        .rs1_d          (rs1_d),
        .imm12_d        (imm12_d)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] target;
        logic [31:0] first;
        logic [31:0] second;
    } redir_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rsp_lat = 1;
    bit   kill_req = 1'b0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return ((a ^ 32'h5A5A_1234) * 32'h0101_0107) + 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input string name, input logic [31:0] exp);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                found = 1'b1;
                check(name, imem_addr, exp);
            end
        end
        if (!found) timeout_fail(name);
    endtask

    // Memory model: answers an accepted request rsp_lat cycles later and
    // records which returns the decode slot should eventually show.
    initial begin : responder
        logic        pend;
        logic [31:0] paddr;
        int          cnt;
        pend = 1'b0;
        paddr = '0;
        cnt = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        forever begin
            @(negedge clk);
            if (imem_rsp_valid) begin
                if (!kill_req && !redirect_valid && !reset)
                    sb.push_back('{paddr, memword(paddr)});
                kill_req = 1'b0;
                pend = 1'b0;
            end else if (pend && redirect_valid) begin
                kill_req = 1'b1;
            end
            if (!reset && imem_req_valid && imem_req_ready) begin
                pend = 1'b1;
                paddr = imem_addr;
                cnt = rsp_lat;
                kill_req = redirect_valid;
            end
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data = memword(paddr);
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Every edge with stall_d low that leaves valid_d high loaded a new word.
    initial begin : monitor
        logic st;
        exp_t e;
        forever begin
            @(posedge clk);
            st = stall_d || reset;
            @(negedge clk);
            if (!reset && !st && valid_d) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_delivery: got pc %h expected no delivery", pc_d);
                end else begin
                    e = sb.pop_front();
                    check("d_pc", pc_d, e.pc);
                    check("d_instr", instr_d, e.instr);
                    check("d_pcplus4", pcplus4_d, e.pc + 32'd4);
                    check("d_opcode", opcode_d, e.instr[6:0]);
                    check("d_funct3", funct3_d, e.instr[14:12]);
                    check("d_funct7", funct7_d, e.instr[31:25]);
                    check("d_rd", rd_d, e.instr[11:7]);
                    check("d_rs1", rs1_d, e.instr[19:15]);
                    check("d_imm12", imm12_d, e.instr[31:20]);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        redir_t tbl[5];
        bit     found;
        tbl[0] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204};
        tbl[1] = '{32'h0000_1001, 32'h0000_1000, 32'h0000_1004};
        tbl[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[3] = '{32'h0000_0042, 32'h0000_0040, 32'h0000_0044};
        tbl[4] = '{32'h8000_0006, 32'h8000_0004, 32'h8000_0008};

        reset = 1'b1;
        imem_req_ready = 1'b1;
        stall_d = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;

        repeat (2) @(negedge clk);
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_valid_d", valid_d, 1'b0);
        check("rst_instr_d", instr_d, NOP);
        check("rst_pc_d", pc_d, 32'h0);

        step();
        reset = 1'b0;
        @(negedge clk);
        check("first_req_valid", imem_req_valid, 1'b1);
        check("first_addr", imem_addr, 32'h0);

        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = imem_rsp_valid;
        end
        if (!found) timeout_fail("first_rsp");

        // stall across the 0x4 return: it must park in the buffer
        step();
        stall_d = 1'b1;
        @(negedge clk);
        check("stall_d_valid", valid_d, 1'b1);
        check("stall_d_pc", pc_d, 32'h0);
        check("req4_valid", imem_req_valid, 1'b1);
        check("req4_addr", imem_addr, 32'h4);
        step();
        @(negedge clk);
        check("stall_hold_pc", pc_d, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            check("buf_full_no_req", imem_req_valid, 1'b0);
            check("stall_hold_pc", pc_d, 32'h0);
            check("stall_hold_instr", instr_d, memword(32'h0));
        end
        step();
        stall_d = 1'b0;
        rsp_lat = 3;
        @(negedge clk);
        check("drain_no_req", imem_req_valid, 1'b0);
        check("drain_pc_d", pc_d, 32'h0);
        step();
        stall_d = 1'b1;
        @(negedge clk);
        check("from_buf_pc", pc_d, 32'h4);
        check("req8_valid", imem_req_valid, 1'b1);
        check("req8_addr", imem_addr, 32'h8);

        // redirect while waiting for 0x8, with decode stalled
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        @(negedge clk);
        check("pre_flush_valid", valid_d, 1'b1);
        check("pre_flush_pc", pc_d, 32'h4);
        step();
        redirect_valid = 1'b0;
        stall_d = 1'b0;
        rsp_lat = 1;
        @(negedge clk);
        check("flush_valid_d", valid_d, 1'b0);
        check("flush_instr_d", instr_d, NOP);
        check("kill_no_req", imem_req_valid, 1'b0);
        wait_hs("redir_addr_100", 32'h0000_0100);
        wait_hs("seq_addr_104", 32'h0000_0104);

        // redirect on the very cycle a request is accepted
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0010;
        @(negedge clk);
        check("hs108_valid", imem_req_valid, 1'b1);
        check("hs108_addr", imem_addr, 32'h0000_0108);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("hs_kill_no_req", imem_req_valid, 1'b0);
        wait_hs("redir_addr_10", 32'h0000_0010);

        // redirect coinciding with the 0x10 response, then ready held low
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0203;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) step();
            @(negedge clk);
            check("noready_req_valid", imem_req_valid, 1'b1);
            check("noready_addr", imem_addr, 32'h0000_0200);
        end
        step();
        imem_req_ready = 1'b1;
        wait_hs("ready_addr_200", 32'h0000_0200);
        wait_hs("ready_addr_204", 32'h0000_0204);

        for (int i = 0; i < 5; i++) begin
            step();
            rsp_lat = $urandom_range(1, 3);
            repeat ($urandom_range(0, 4)) step();
            redirect_valid = 1'b1;
            redirect_pc = tbl[i].target;
            step();
            redirect_valid = 1'b0;
            wait_hs("tbl_first", tbl[i].first);
            wait_hs("tbl_second", tbl[i].second);
        end

        // reset in WAIT, stale response in the first REQ cycle afterwards
        step();
        rsp_lat = 3;
        wait_hs("pre_reset_hs", tbl[4].second + 32'd4);
        step();
        reset = 1'b1;
        kill_req = 1'b1;
        rsp_lat = 1;
        @(negedge clk);
        check("mid_rst_req_valid", imem_req_valid, 1'b0);
        check("mid_rst_valid_d", valid_d, 1'b0);
        check("mid_rst_instr_d", instr_d, NOP);
        check("mid_rst_pc_d", pc_d, 32'h0);
        step();
        @(negedge clk);
        check("mid_rst_req_valid2", imem_req_valid, 1'b0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("restart_req_valid", imem_req_valid, 1'b1);
        check("restart_addr", imem_addr, 32'h0);
        check("stale_ignored", valid_d, 1'b0);
        step();
        @(negedge clk);
        check("restart_wait_valid", valid_d, 1'b0);
        repeat (6) step();
        @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
